alu_bool_pipe: RTL and testbench
================================

# alu_bool_pipe

Parametrised, pipelined successor of the single-op 32-bit boolean unit. It evaluates ten bitwise boolean operations over `WIDTH`-bit operands and keeps the existing XOR encoding. Results pass through a `STAGES`-deep elastic pipeline with valid/ready handshakes on both sides, and each result carries zero and illegal-opcode flags. It sits in the ALU datapath beside the arithmetic units, and the ALU issue logic drives it.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width in bits (≥1).
- `STAGES`, 2: pipeline register depth (1..4).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand transaction offered.
- `in_ready`  out  1  block accepts transaction this cycle.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `opcode`  in  4  operation select.
- `en`  in  1  operation enable, sampled with the transaction.
- `out_valid`  out  1  result transaction present.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  operation result.
- `zero`  out  1  result == 0.
- `illegal`  out  1  opcode was unassigned.

## Operation
- Handshake: an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- Opcodes:
  - 0000 AND (A&B), 0001 OR (A|B), 0010 NAND, 0011 NOR.
  - 0100 XOR (A^B, unchanged encoding), 0101 XNOR.
  - 0110 ANDN (A&~B), 0111 ORN (A|~B), 1000 PASSA (A), 1001 NOTA (~A).
  - 1010–1111 are illegal.
- Result per transaction is computed combinationally at acceptance:
  - `en`=0: result 0, illegal=0, regardless of opcode.
  - `en`=1 with an illegal opcode: result 0, illegal=1.
  - In all cases zero = (result == 0).
- Pipeline: `STAGES` slots, each holding {valid, result, zero, illegal}. Slot 0 captures at acceptance; the last slot drives the outputs.
- Slot advance rule: slot k loads from slot k-1 when slot k is empty or slot k is being emptied this cycle. A slot is emptied when it transfers downstream (the last slot transfers on an output transfer).
- `in_ready` = slot 0 empty or slot 0 advancing. This gives full throughput of one transaction per cycle under continuous `out_ready`.
- Backpressure: with `out_ready`=0 the pipeline fills. Bubbles collapse, so up to `STAGES` transactions are buffered. `in_ready` drops only when all slots are valid and `out_ready`=0.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.
- While `out_valid`=1 and `out_ready`=0, `result`/`zero`/`illegal` hold stable.
- Simultaneous output transfer and input acceptance with a full pipeline is legal: every slot shifts and the count is unchanged.
- Reset mid-operation: all in-flight transactions are discarded. There is no output transfer in the reset cycle.

## Timing
- Reset values: `out_valid`=0, `result`=0, `zero`=0, `illegal`=0, all slot valids 0.
- `in_ready`=1 in the first cycle after reset deassertion.
- Latency: a transaction accepted at edge n is presented with `out_valid`=1 after edge n+`STAGES-1` (visible in cycle n+STAGES), assuming no stalls.
- `in_ready` has a combinational path from `out_ready` (ready chain through slots). There is no combinational path from `in_valid` or operands to any output.
- Payload registers update only on load. Valid bits clear on empty without load.

## Structure
- Package `alu_bool_pkg`:
  - `typedef enum logic [3:0] bool_op_e` with all ten opcodes.
  - Function `is_legal_op`.
  - Localparam `MAX_STAGES` = 4.
  - Packed struct type for slot payload: result, zero, illegal. Width comes from the module parameter, so it is declared locally or as a parametrised struct in the module.
- Sub-module `alu_bool_slot`: one elastic register slot holding valid and payload, with an up_valid/up_ready and down_valid/down_ready pair. It is instantiated `STAGES` times in a generate loop.
- Compute logic is one `always_comb` case in the top, ahead of slot 0.
- Elaboration check: `STAGES` in 1..`MAX_STAGES`, `WIDTH` ≥ 1.

## Test plan
- Reset, then one XOR at WIDTH=32, STAGES=2: A=0xFFFF0000, B=0x0F0F0F0F, en=1, out_ready=1. Expect result=0xF0F00F0F, zero=0, illegal=0, out_valid exactly 2 cycles after acceptance.
- Sweep all 16 opcodes back-to-back with A=0xA5A5A5A5, B=0x0000FFFF, out_ready=1. Expect one result per cycle in order:
  - AND=0x0000A5A5, NOR=0x5A5A0000, ANDN=0xA5A50000, NOTA=0x5A5A5A5A.
  - Opcodes 1010–1111 give 0 with illegal=1, zero=1.
- en=0 with opcode XOR, A=B=0x12345678: result=0, zero=1, illegal=0.
- Backpressure at STAGES=3: hold out_ready=0 and offer 5 transactions. Expect exactly 3 accepted, then in_ready=0 and outputs stable. Release out_ready: results drain in order, and the 4th and 5th are accepted as slots free.
- Random in_valid/out_ready toggling at WIDTH=8 and STAGES=1 and 4, with a scoreboard over 10k transactions. No loss, no duplication, order preserved.
- Assert rst while 2 transactions are in flight. Next cycle out_valid=0 and result=0, in_ready=1. No stale result emerges afterwards.

Source files
------------

// File: rtl/alu_bool_pipe_pkg.sv
// Shared opcode encoding, legality test and depth limit for the pipelined boolean unit.
// Opcode values keep the XOR encoding of the original single-op unit.
package alu_bool_pkg;

  localparam int MAX_STAGES = 4;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_NAND  = 4'b0010,
    OP_NOR   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_XNOR  = 4'b0101,
    OP_ANDN  = 4'b0110,
    OP_ORN   = 4'b0111,
    OP_PASSA = 4'b1000,
    OP_NOTA  = 4'b1001
  } bool_op_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

endpackage

// File: rtl/alu_bool_pipe_if.sv
// Operand/result handshake bundle: issue side (in_*) and consumer side (out_*).
// The master drives operands and out_ready; the slave (the ALU block) answers.
interface alu_bool_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic             en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, A, B, opcode, en, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, A, B, opcode, en, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_bool_pipe_slot.sv
// One elastic register slot, 1-cycle latency; up_ready = empty or draining this cycle,
// so the ready path is combinational from down_ready and bubbles collapse.
module alu_bool_slot #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_dat,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [DW-1:0] down_dat
);

  logic          vld_q;
  logic [DW-1:0] dat_q;

  assign up_ready   = !vld_q || down_ready;
  assign down_valid = vld_q;
  assign down_dat   = dat_q;

  // When up_ready is low the slot is full and stalled, so valid simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (up_ready) begin
      vld_q <= up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
    end else if (up_valid && up_ready) begin
      dat_q <= up_dat;
    end
  end

endmodule

// File: rtl/alu_bool_pipe.sv
// Ten-op bitwise unit feeding a STAGES-deep elastic pipeline; result visible STAGES cycles after accept.
// Holds up to STAGES results under out_ready=0; in_ready falls only when every slot is full and stalled.
module alu_bool_pipe
  import alu_bool_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  alu_bool_pipe_if.slave bus
);

  if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1) begin : g_param_check
    $error("alu_bool_pipe: WIDTH must be >= 1 and STAGES within 1..MAX_STAGES");
  end

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
  } slot_t;

  slot_t             comp;
  slot_t             dat [STAGES+1];
  logic [STAGES:0]   vld;
  logic [STAGES:0]   rdy;

  // Disabled transactions and unassigned opcodes both produce a zero result.
  always_comb begin
    comp = '0;
    if (bus.en) begin
      comp.illegal = !is_legal_op(bus.opcode);
      case (bool_op_e'(bus.opcode))
        OP_AND:   comp.result = bus.A & bus.B;
        OP_OR:    comp.result = bus.A | bus.B;
        OP_NAND:  comp.result = ~(bus.A & bus.B);
        OP_NOR:   comp.result = ~(bus.A | bus.B);
        OP_XOR:   comp.result = bus.A ^ bus.B;
        OP_XNOR:  comp.result = ~(bus.A ^ bus.B);
        OP_ANDN:  comp.result = bus.A & ~bus.B;
        OP_ORN:   comp.result = bus.A | ~bus.B;
        OP_PASSA: comp.result = bus.A;
        OP_NOTA:  comp.result = ~bus.A;
        default:  comp.result = '0;
      endcase
    end
    comp.zero = (comp.result == '0);
  end

  assign vld[0]      = bus.in_valid;
  assign dat[0]      = comp;
  assign bus.in_ready = rdy[0];
  assign rdy[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    alu_bool_slot #(
      .DW($bits(slot_t))
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (vld[k]),
      .up_ready   (rdy[k]),
      .up_dat     (dat[k]),
      .down_valid (vld[k+1]),
      .down_ready (rdy[k+1]),
      .down_dat   (dat[k+1])
    );
  end

  assign bus.out_valid = vld[STAGES];
  assign bus.result    = dat[STAGES].result;
  assign bus.zero      = dat[STAGES].zero;
  assign bus.illegal   = dat[STAGES].illegal;

endmodule

// File: tb/tb_alu_bool_pipe.sv
// Four DUT configurations share one clock; each has a queue-based scoreboard fed by a truth-table model.
// Directed sequences run on the 32-bit instances, random traffic on the 8-bit STAGES=1 and STAGES=4 ones.
module tb_alu_bool_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int vectors     = 0;
  int miscompares = 0;

  // Per-instance stimulus and observation, 32 bits wide regardless of the instance width.
  logic        v_s  [4];
  logic        or_s [4];
  logic        en_s [4];
  logic [31:0] a_s  [4];
  logic [31:0] b_s  [4];
  logic [3:0]  op_s [4];
  logic        ir_s [4];
  logic        ov_s [4];
  logic        z_s  [4];
  logic        il_s [4];
  logic [31:0] r_s  [4];
  int          acc_cnt [4] = '{0, 0, 0, 0};
  int          out_cnt [4] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Each opcode as a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [3:0] truth(input logic [3:0] op);
    case (op)
      4'd0:    return 4'b1000;
      4'd1:    return 4'b1110;
      4'd2:    return 4'b0111;
      4'd3:    return 4'b0001;
      4'd4:    return 4'b0110;
      4'd5:    return 4'b1001;
      4'd6:    return 4'b0100;
      4'd7:    return 4'b1101;
      4'd8:    return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  // Returns {result[31:0], zero, illegal} for a w-bit unit.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic e, input int w);
    logic [31:0] r;
    logic [3:0]  t;
    logic        il;
    r  = '0;
    il = 1'b0;
    if (e && op > 4'd9) begin
      il = 1'b1;
    end else if (e) begin
      t = truth(op);
      for (int i = 0; i < w; i++) r[i] = t[{a[i], b[i]}];
    end
    return {r, (r == 32'd0), il};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen
    localparam int W = (g < 2) ? 32 : 8;
    localparam int S = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;

    alu_bool_pipe_if #(.WIDTH(W)) ifc ();

    alu_bool_pipe #(
      .WIDTH (W),
      .STAGES(S)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
    );

    assign ifc.in_valid  = v_s[g];
    assign ifc.out_ready = or_s[g];
    assign ifc.en        = en_s[g];
    assign ifc.A         = a_s[g][W-1:0];
    assign ifc.B         = b_s[g][W-1:0];
    assign ifc.opcode    = op_s[g];
    assign ir_s[g]       = ifc.in_ready;
    assign ov_s[g]       = ifc.out_valid;
    assign z_s[g]        = ifc.zero;
    assign il_s[g]       = ifc.illegal;
    assign r_s[g]        = 32'(ifc.result);

    logic [33:0] q[$];
    logic        stall_q = 1'b0;
    logic [33:0] held;

    // Decides at the falling edge what the coming rising edge will transfer.
    always @(negedge clk) begin
      logic [33:0] cur;
      logic [33:0] e;
      cur = {32'(ifc.result), ifc.zero, ifc.illegal};
      if (rst) begin
        q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk($sformatf("g%0d hold_valid", g), ifc.out_valid, 1);
          chk($sformatf("g%0d hold_payload", g), cur, held);
        end
        chk($sformatf("g%0d in_ready", g), ifc.in_ready, (q.size() < S) || ifc.out_ready);
        if (ifc.out_valid && ifc.out_ready) begin
          chk($sformatf("g%0d out_has_item", g), q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("g%0d sb_result", g), cur, e);
          end
          out_cnt[g]++;
        end
        if (ifc.in_valid && ifc.in_ready) begin
          q.push_back(model(ifc.opcode, 32'(ifc.A), 32'(ifc.B), ifc.en, W));
          acc_cnt[g]++;
        end
        stall_q = ifc.out_valid && !ifc.out_ready;
        held    = cur;
      end
    end
  end

  // Directed sequence buffers.
  logic [31:0] d_a  [16];
  logic [31:0] d_b  [16];
  logic [3:0]  d_op [16];
  logic        d_en [16];
  logic [31:0] o_r  [16];
  logic        o_z  [16];
  logic        o_i  [16];
  int          acc_e[16];
  int          out_e[16];
  int          bp_acc;
  logic        bp_ir;

  logic [31:0] sweep_exp [10] = '{32'h0000A5A5, 32'hA5A5FFFF, 32'hFFFF5A5A, 32'h5A5A0000,
                                  32'hA5A55A5A, 32'h5A5AA5A5, 32'hA5A50000, 32'hFFFFA5A5,
                                  32'hA5A5A5A5, 32'h5A5A5A5A};

  // Offers d_* items in order on instance g, out_ready low for the first `stall` cycles.
  task automatic run(input int g, input int n, input int stall);
    int ai, oi, t;
    ai = 0; oi = 0; t = 0;
    while (oi < n && t < 300) begin
      v_s[g] = (ai < n);
      if (ai < n) begin
        a_s[g] = d_a[ai]; b_s[g] = d_b[ai]; op_s[g] = d_op[ai]; en_s[g] = d_en[ai];
      end
      or_s[g] = (t >= stall);
      @(negedge clk);
      if (t == stall - 1) begin
        bp_acc = ai;
        bp_ir  = ir_s[g];
      end
      if (v_s[g] && ir_s[g]) begin
        acc_e[ai] = cyc + 1;
        ai++;
      end
      if (ov_s[g] && or_s[g]) begin
        o_r[oi] = r_s[g]; o_z[oi] = z_s[g]; o_i[oi] = il_s[g]; out_e[oi] = cyc;
        oi++;
      end
      @(posedge clk); #1;
      t++;
    end
    v_s[g]  = 1'b0;
    or_s[g] = 1'b1;
    chk($sformatf("g%0d run_complete", g), oi, n);
  endtask

  task automatic rnd(input int g, input int n);
    int a0, t;
    a0 = acc_cnt[g];
    t  = 0;
    while ((acc_cnt[g] - a0 < n || out_cnt[g] != acc_cnt[g]) && t < 60000) begin
      v_s[g]  = (acc_cnt[g] - a0 < n) && ($urandom_range(0, 3) != 0);
      a_s[g]  = $urandom;
      b_s[g]  = $urandom;
      op_s[g] = 4'($urandom_range(0, 15));
      en_s[g] = ($urandom_range(0, 7) != 0);
      or_s[g] = ($urandom_range(0, 3) != 0) || (acc_cnt[g] - a0 >= n);
      @(posedge clk); #1;
      t++;
    end
    v_s[g] = 1'b0;
    chk($sformatf("g%0d rnd_accepted", g), acc_cnt[g] - a0, n);
    chk($sformatf("g%0d rnd_drained", g), out_cnt[g], acc_cnt[g]);
  endtask

  initial begin
    logic [33:0] m;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v_s[k] = 1'b0; or_s[k] = 1'b1; en_s[k] = 1'b0;
      a_s[k] = '0;   b_s[k] = '0;    op_s[k] = '0;
    end

    // Hand-computed values pinning the reference model.
    m = model(4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32);
    chk("model_xor", m, {32'hF0F00F0F, 1'b0, 1'b0});
    m = model(4'd3, 32'hA5A5A5A5, 32'h0000FFFF, 1'b1, 32);
    chk("model_nor", m[33:2], 32'h5A5A0000);
    m = model(4'd7, 32'hA5A5A5A5, 32'h0000FFFF, 1'b1, 32);
    chk("model_orn", m[33:2], 32'hFFFFA5A5);
    m = model(4'd12, 32'hA5A5A5A5, 32'h0000FFFF, 1'b1, 32);
    chk("model_illegal", m, {32'h0, 1'b1, 1'b1});
    m = model(4'd9, 32'h000000F0, 32'h0, 1'b1, 8);
    chk("model_nota_w8", m[33:2], 32'h0000000F);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", ov_s[0], 0);
    chk("reset_result", r_s[0], 0);
    chk("reset_zero", z_s[0], 0);
    chk("reset_illegal", il_s[0], 0);
    chk("reset_out_valid_s4", ov_s[3], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", ir_s[0], 1);
    chk("in_ready_after_reset_s3", ir_s[1], 1);
    @(posedge clk); #1;

    // Single XOR, latency STAGES-1 edges after the accepting edge.
    d_a[0] = 32'hFFFF0000; d_b[0] = 32'h0F0F0F0F; d_op[0] = 4'd4; d_en[0] = 1'b1;
    run(0, 1, 0);
    chk("xor_result", o_r[0], 32'hF0F00F0F);
    chk("xor_zero", o_z[0], 0);
    chk("xor_illegal", o_i[0], 0);
    chk("xor_latency", out_e[0] - acc_e[0], 1);

    // All sixteen opcodes back to back.
    for (int k = 0; k < 16; k++) begin
      d_a[k] = 32'hA5A5A5A5; d_b[k] = 32'h0000FFFF; d_op[k] = 4'(k); d_en[k] = 1'b1;
    end
    run(0, 16, 0);
    chk("sweep_in_rate", acc_e[15] - acc_e[0], 15);
    chk("sweep_out_rate", out_e[15] - out_e[0], 15);
    for (int k = 0; k < 16; k++) begin
      if (k < 10) begin
        chk($sformatf("sweep_op%0d_result", k), o_r[k], sweep_exp[k]);
        chk($sformatf("sweep_op%0d_illegal", k), o_i[k], 0);
      end else begin
        chk($sformatf("sweep_op%0d_result", k), o_r[k], 0);
        chk($sformatf("sweep_op%0d_zero", k), o_z[k], 1);
        chk($sformatf("sweep_op%0d_illegal", k), o_i[k], 1);
      end
    end

    // Disabled transactions: zero result, never illegal.
    d_a[0] = 32'h12345678; d_b[0] = 32'h12345678; d_op[0] = 4'd4;  d_en[0] = 1'b0;
    d_a[1] = 32'hA5A5A5A5; d_b[1] = 32'h0000FFFF; d_op[1] = 4'd1;  d_en[1] = 1'b0;
    d_a[2] = 32'hA5A5A5A5; d_b[2] = 32'h0000FFFF; d_op[2] = 4'd12; d_en[2] = 1'b0;
    run(0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("en0_%0d_result", k), o_r[k], 0);
      chk($sformatf("en0_%0d_zero", k), o_z[k], 1);
      chk($sformatf("en0_%0d_illegal", k), o_i[k], 0);
    end

    // Backpressure on STAGES=3: five offered, three fit while stalled.
    for (int k = 0; k < 5; k++) begin
      d_a[k] = 32'(k + 1); d_b[k] = 32'h0; d_op[k] = 4'd8; d_en[k] = 1'b1;
    end
    run(1, 5, 8);
    chk("bp_accepted_while_stalled", bp_acc, 3);
    chk("bp_in_ready_while_full", bp_ir, 0);
    for (int k = 0; k < 5; k++) chk($sformatf("bp_order_%0d", k), o_r[k], k + 1);

    // Reset with two transactions in flight.
    or_s[0] = 1'b0; v_s[0] = 1'b1; op_s[0] = 4'd8; en_s[0] = 1'b1; a_s[0] = 32'hDEAD0001;
    @(posedge clk); #1;
    a_s[0] = 32'hDEAD0002;
    @(posedge clk); #1;
    v_s[0] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("inflight_before_reset", ov_s[0], 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", ov_s[0], 0);
    chk("post_reset_result", r_s[0], 0);
    chk("post_reset_in_ready", ir_s[0], 1);
    or_s[0] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_result", ov_s[0], 0);
    end
    @(posedge clk); #1;

    // Random traffic on the 8-bit instances.
    fork
      rnd(2, 10000);
      rnd(3, 10000);
    join

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
